lsq_issue_sched: RTL and testbench

Per-channel issue scheduler between the LSQ credit grant and the memory crossbar. Each cycle it picks, for each of the three channels, the oldest LSQ entry that is valid, credit-granted (`entry_can_execute`) and not yet issued. It presents that entry's index to the crossbar on a registered valid/ready port. It tracks which entries are already issued so each granted entry goes out exactly once until the LSQ deallocates it.

---
 rtl/lsq_issue_sched_if.sv | 11 +
 rtl/lsq_issue_sched.sv | 100 ++++++++++
 tb/tb_lsq_issue_sched.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/lsq_issue_sched_if.sv
// Issue port between the LSQ scheduler and the memory crossbar: one valid/ready lane per channel.
interface lsq_issue_sched_if #(
  parameter int LSQ_IDX_W = 4
);
  logic [2:0]                iss_valid;
  logic [2:0][LSQ_IDX_W-1:0] iss_lsq_idx;
  logic [2:0]                iss_ready;

  modport master (output iss_valid, output iss_lsq_idx, input iss_ready);
  modport slave  (input iss_valid, input iss_lsq_idx, output iss_ready);
endinterface

// File: rtl/lsq_issue_sched.sv
// Per-channel oldest-first issue of credit-granted LSQ entries; 1 cycle select-to-valid, 1 issue/channel/cycle.
// Registered valid/idx hold while the crossbar withholds ready; dealloc of the held entry or flush drops it.
module lsq_issue_sched #(
  parameter int LSQ_SIZE  = 16,
  parameter int LSQ_IDX_W = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [LSQ_SIZE-1:0]       entry_can_execute,
  input  logic [LSQ_SIZE-1:0]       lsq_entry_vld,
  input  logic [LSQ_SIZE-1:0][1:0]  lsq_entry_channel_id,
  input  logic [LSQ_IDX_W-1:0]      lsq_btm_ptr,
  input  logic [LSQ_SIZE-1:0]       lsq_entry_dealloc,
  input  logic                      flush,
  lsq_issue_sched_if.master         iss,
  output logic [LSQ_SIZE-1:0]       entry_issued
);

  typedef enum logic {IDLE, REQ} state_t;

  state_t                    state_q [3];
  logic [2:0][LSQ_IDX_W-1:0] idx_q;
  logic [2:0][LSQ_SIZE-1:0]  cand;
  logic [2:0][LSQ_IDX_W-1:0] sel;
  logic [2:0]                any;
  logic [2:0]                held_dealloc;
  logic [2:0]                load;
  logic [LSQ_SIZE-1:0]       set_mask;
  logic [LSQ_IDX_W-1:0]      pos;

  always_comb begin
    for (int c = 0; c < 3; c++) begin
      for (int j = 0; j < LSQ_SIZE; j++) begin
        cand[c][j] = lsq_entry_vld[j] & entry_can_execute[j] & ~entry_issued[j] &
                     ~lsq_entry_dealloc[j] & (lsq_entry_channel_id[j] == 2'(c));
      end
    end
  end

  // Scan from the youngest offset down so the entry closest to btm_ptr wins last.
  always_comb begin
    pos = '0;
    sel = '0;
    any = '0;
    for (int c = 0; c < 3; c++) begin
      for (int i = LSQ_SIZE - 1; i >= 0; i--) begin
        pos = lsq_btm_ptr + LSQ_IDX_W'(i);
        if (cand[c][pos]) begin
          any[c] = 1'b1;
          sel[c] = pos;
        end
      end
    end
  end

  always_comb begin
    set_mask = '0;
    for (int c = 0; c < 3; c++) begin
      held_dealloc[c] = lsq_entry_dealloc[idx_q[c]];
      load[c] = ~flush & any[c] &
                ((state_q[c] == IDLE) | (~held_dealloc[c] & iss.iss_ready[c]));
      if (load[c]) set_mask[sel[c]] = 1'b1;
    end
  end

  always_comb begin
    for (int c = 0; c < 3; c++) iss.iss_valid[c] = (state_q[c] == REQ);
    iss.iss_lsq_idx = idx_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_issued <= '0;
    end else if (flush) begin
      entry_issued <= '0;
    end else begin
      entry_issued <= (entry_issued & ~lsq_entry_dealloc) | set_mask;
    end
  end

  // Losing the held entry to dealloc drops the request without counting it as a handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      for (int c = 0; c < 3; c++) state_q[c] <= IDLE;
    end else begin
      for (int c = 0; c < 3; c++) begin
        if (flush) begin
          state_q[c] <= IDLE;
        end else if (load[c]) begin
          state_q[c] <= REQ;
          idx_q[c]   <= sel[c];
        end else if (state_q[c] == REQ && (held_dealloc[c] || iss.iss_ready[c])) begin
          state_q[c] <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_lsq_issue_sched.sv
// Directed table-driven bench for lsq_issue_sched plus an asynchronous-reset sequence.
module tb_lsq_issue_sched;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [15:0]       entry_can_execute = '0;
  logic [15:0]       lsq_entry_vld = '0;
  logic [15:0][1:0]  lsq_entry_channel_id = '1;
  logic [3:0]        lsq_btm_ptr = '0;
  logic [15:0]       lsq_entry_dealloc = '0;
  logic              flush = 1'b0;
  logic [15:0]       entry_issued;

  lsq_issue_sched_if #(.LSQ_IDX_W(4)) iss_if ();

  lsq_issue_sched #(.LSQ_SIZE(16), .LSQ_IDX_W(4)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .entry_can_execute    (entry_can_execute),
    .lsq_entry_vld        (lsq_entry_vld),
    .lsq_entry_channel_id (lsq_entry_channel_id),
    .lsq_btm_ptr          (lsq_btm_ptr),
    .lsq_entry_dealloc    (lsq_entry_dealloc),
    .flush                (flush),
    .iss                  (iss_if),
    .entry_issued         (entry_issued)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          rst;
    logic [15:0] vld;
    logic [15:0] ce;
    logic [31:0] ch;
    logic [3:0]  btm;
    logic [15:0] dea;
    bit          fl;
    logic [2:0]  rdy;
    logic [2:0]  ev;
    logic [3:0]  ei [3];
    logic [15:0] eiss;
  } vec_t;

  vec_t vq[$];
  int   tests = 0;
  int   failed = 0;

  function automatic logic [31:0] chmap(input int e0, input int c0, input int e1,
                                        input int c1, input int e2, input int c2);
    logic [31:0] m;
    m = '1;
    if (e0 >= 0) m[2*e0 +: 2] = c0[1:0];
    if (e1 >= 0) m[2*e1 +: 2] = c1[1:0];
    if (e2 >= 0) m[2*e2 +: 2] = c2[1:0];
    return m;
  endfunction

  task automatic add(input string nm, input bit rst, input logic [15:0] vld, input logic [15:0] ce,
                     input logic [31:0] ch, input logic [3:0] btm, input logic [15:0] dea,
                     input bit fl, input logic [2:0] rdy, input logic [2:0] ev,
                     input logic [3:0] i0, input logic [3:0] i1, input logic [3:0] i2,
                     input logic [15:0] eiss);
    vec_t v;
    v.name = nm; v.rst = rst; v.vld = vld; v.ce = ce; v.ch = ch; v.btm = btm; v.dea = dea;
    v.fl = fl; v.rdy = rdy; v.ev = ev; v.ei[0] = i0; v.ei[1] = i1; v.ei[2] = i2; v.eiss = eiss;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic drive_zero();
    entry_can_execute = '0; lsq_entry_vld = '0; lsq_entry_channel_id = '1;
    lsq_btm_ptr = '0; lsq_entry_dealloc = '0; flush = 1'b0; iss_if.iss_ready = '0;
  endtask

  task automatic check_reset_values(input string nm);
    chk({nm, " iss_valid"}, 32'(iss_if.iss_valid), 32'h0);
    chk({nm, " iss_lsq_idx"}, 32'(iss_if.iss_lsq_idx), 32'h0);
    chk({nm, " entry_issued"}, 32'(entry_issued), 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive_zero();
    @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] m;
    iss_if.iss_ready = '0;

    // Single entry 3 on channel 0.
    m = chmap(3, 0, -1, 0, -1, 0);
    add("single_sel",   1, 16'h0008, 16'h0008, m, 0, 16'h0000, 0, 3'b001, 3'b001, 3, 0, 0, 16'h0008);
    add("single_idle",  0, 16'h0008, 16'h0008, m, 0, 16'h0000, 0, 3'b001, 3'b000, 0, 0, 0, 16'h0008);
    add("single_dealc", 0, 16'h0008, 16'h0008, m, 0, 16'h0008, 0, 3'b001, 3'b000, 0, 0, 0, 16'h0000);
    // Wrap: btm 14, entries 15, 0, 1 on channel 1.
    m = chmap(15, 1, 0, 1, 1, 1);
    add("wrap_15",      1, 16'h8003, 16'h8003, m, 14, 16'h0000, 0, 3'b010, 3'b010, 0, 15, 0, 16'h8000);
    add("wrap_0",       0, 16'h8003, 16'h8003, m, 14, 16'h0000, 0, 3'b010, 3'b010, 0, 0, 0, 16'h8001);
    add("wrap_1",       0, 16'h8003, 16'h8003, m, 14, 16'h0000, 0, 3'b010, 3'b010, 0, 1, 0, 16'h8003);
    add("wrap_done",    0, 16'h8003, 16'h8003, m, 14, 16'h0000, 0, 3'b010, 3'b000, 0, 0, 0, 16'h8003);
    // Backpressure on channel 2 with entries 4 and 6.
    m = chmap(4, 2, 6, 2, -1, 0);
    add("bp_hold1",     1, 16'h0050, 16'h0050, m, 0, 16'h0000, 0, 3'b000, 3'b100, 0, 0, 4, 16'h0010);
    for (int k = 2; k <= 5; k++)
      add($sformatf("bp_hold%0d", k), 0, 16'h0050, 16'h0050, m, 0, 16'h0000, 0, 3'b000, 3'b100, 0, 0, 4, 16'h0010);
    add("bp_next6",     0, 16'h0050, 16'h0050, m, 0, 16'h0000, 0, 3'b100, 3'b100, 0, 0, 6, 16'h0050);
    add("bp_done",      0, 16'h0050, 16'h0050, m, 0, 16'h0000, 0, 3'b100, 3'b000, 0, 0, 0, 16'h0050);
    // Parallel channels, then flush with ready high, then reselection.
    m = chmap(2, 0, 5, 1, 9, 2);
    add("par_sel",      1, 16'h0224, 16'h0224, m, 0, 16'h0000, 0, 3'b000, 3'b111, 2, 5, 9, 16'h0224);
    add("par_hold",     0, 16'h0224, 16'h0224, m, 0, 16'h0000, 0, 3'b000, 3'b111, 2, 5, 9, 16'h0224);
    add("flush",        0, 16'h0224, 16'h0224, m, 0, 16'h0000, 1, 3'b111, 3'b000, 0, 0, 0, 16'h0000);
    add("post_flush",   0, 16'h0224, 16'h0224, m, 0, 16'h0000, 0, 3'b000, 3'b111, 2, 5, 9, 16'h0224);
    // Dealloc of held entry 7 with ready low, then of held entry 10 with ready high.
    m = chmap(7, 0, 10, 0, -1, 0);
    add("dea_sel7",     1, 16'h0480, 16'h0480, m, 0, 16'h0000, 0, 3'b000, 3'b001, 7, 0, 0, 16'h0080);
    add("dea_drop7",    0, 16'h0480, 16'h0480, m, 0, 16'h0080, 0, 3'b000, 3'b000, 0, 0, 0, 16'h0000);
    add("dea_sel10",    0, 16'h0400, 16'h0400, m, 0, 16'h0000, 0, 3'b000, 3'b001, 10, 0, 0, 16'h0400);
    add("dea_drop10",   0, 16'h0400, 16'h0400, m, 0, 16'h0400, 0, 3'b001, 3'b000, 0, 0, 0, 16'h0000);
    // Dealloc and select of the same entry in one cycle.
    m = chmap(5, 1, -1, 0, -1, 0);
    add("dea_vs_sel",   1, 16'h0020, 16'h0020, m, 0, 16'h0020, 0, 3'b010, 3'b000, 0, 0, 0, 16'h0000);
    // Channel id 3 is never selected.
    m = chmap(-1, 0, -1, 0, -1, 0);
    add("chan3_a",      1, 16'h0001, 16'h0001, m, 0, 16'h0000, 0, 3'b111, 3'b000, 0, 0, 0, 16'h0000);
    add("chan3_b",      0, 16'h0001, 16'h0001, m, 0, 16'h0000, 0, 3'b111, 3'b000, 0, 0, 0, 16'h0000);
    // Credit withdrawn after selection keeps the issue.
    m = chmap(12, 2, -1, 0, -1, 0);
    add("ce_sel",       1, 16'h1000, 16'h1000, m, 0, 16'h0000, 0, 3'b000, 3'b100, 0, 0, 12, 16'h1000);
    add("ce_drop_hold", 0, 16'h1000, 16'h0000, m, 0, 16'h0000, 0, 3'b000, 3'b100, 0, 0, 12, 16'h1000);
    add("ce_drop_hs",   0, 16'h1000, 16'h0000, m, 0, 16'h0000, 0, 3'b100, 3'b000, 0, 0, 0, 16'h1000);

    foreach (vq[r]) begin
      if (vq[r].rst) do_reset();
      else @(negedge clk);
      lsq_entry_vld        = vq[r].vld;
      entry_can_execute    = vq[r].ce;
      lsq_entry_channel_id = vq[r].ch;
      lsq_btm_ptr          = vq[r].btm;
      lsq_entry_dealloc    = vq[r].dea;
      flush                = vq[r].fl;
      iss_if.iss_ready     = vq[r].rdy;
      @(posedge clk);
      #1;
      chk({vq[r].name, " iss_valid"}, 32'(iss_if.iss_valid), 32'(vq[r].ev));
      for (int c = 0; c < 3; c++)
        if (vq[r].ev[c])
          chk($sformatf("%s idx%0d", vq[r].name, c), 32'(iss_if.iss_lsq_idx[c]), 32'(vq[r].ei[c]));
      chk({vq[r].name, " entry_issued"}, 32'(entry_issued), 32'(vq[r].eiss));
    end

    // Asynchronous reset while channel 2 is in REQ, then selection on the first edge after release.
    do_reset();
    lsq_entry_vld = 16'h1000; entry_can_execute = 16'h1000;
    lsq_entry_channel_id = chmap(12, 2, -1, 0, -1, 0);
    iss_if.iss_ready = 3'b000;
    @(posedge clk);
    #1;
    chk("arst_pre valid", 32'(iss_if.iss_valid), 32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("arst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_post valid", 32'(iss_if.iss_valid), 32'h4);
    chk("arst_post idx2", 32'(iss_if.iss_lsq_idx[2]), 32'd12);
    chk("arst_post issued", 32'(entry_issued), 32'h1000);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
